// File: rtl/sfx_pkg.sv
// Shared constants for the sound-effect scheduler: sizing, FSM encoding and
// the clip layout of the shared audio ROM.
package sfx_pkg;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 17;
    localparam int GAP_LEN = 16;
    localparam int ID_W    = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    // Clip start addresses and lengths in samples, indexed by requester id.
    // Every base + length stays within the ROM, so addresses never wrap mid-clip.
    localparam logic [ADDR_W-1:0] CLIP_BASE [NUM_REQ] = '{
        17'd0, 17'd6459, 17'd10459, 17'd13459
    };
    localparam logic [ADDR_W-1:0] CLIP_LEN [NUM_REQ] = '{
        17'd6459, 17'd4000, 17'd3000, 17'd2000
    };

endpackage

// File: rtl/sfx_scheduler_prio_pick.sv
// Fixed-priority picker: returns the highest set index of a request vector.
module prio_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    // Ascending scan: the last set bit seen is the highest index.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (vec_i[i]) begin
                idx_o   = IDX_W'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sfx_scheduler.sv
// Sound-effect scheduler: arbitrates one-shot clip requests, walks the audio
// ROM for the granted clip, inserts a silent gap after each clip, and handles
// preemption, retrigger and cancel.
module sfx_scheduler #(
    parameter int NUM_REQ = sfx_pkg::NUM_REQ,
    parameter int ADDR_W  = sfx_pkg::ADDR_W,
    parameter int GAP_LEN = sfx_pkg::GAP_LEN
) (
    input  logic               clk_8000,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               cancel,
    input  logic [7:0]         rom_data,
    output logic [ADDR_W-1:0]  rom_addr,
    output logic [7:0]         audio_out,
    output logic               busy,
    output logic [1:0]         active_id,
    output logic [NUM_REQ-1:0] done
);

    import sfx_pkg::*;

    localparam int GAP_W = (GAP_LEN > 0) ? $clog2(GAP_LEN + 1) : 1;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] pending_q, pending_d;
    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    logic [ADDR_W-1:0]  cnt_q, cnt_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [ID_W-1:0]    active_id_q, active_id_d;
    logic [7:0]         audio_q, audio_d;

    logic [NUM_REQ-1:0] req_all;
    logic [ID_W-1:0]    pick_id;
    logic               pick_valid;
    logic [ADDR_W-1:0]  pick_base;
    logic [ADDR_W-1:0]  act_len;
    logic               in_clip;
    logic               last;
    logic               restart;
    logic               grant;
    logic [NUM_REQ-1:0] done_pulse;

    // Requests arriving this cycle are arbitrated together with stored ones,
    // so a request in IDLE reaches LOAD on the very next cycle.
    assign req_all = pending_q | req;

    prio_pick #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_prio_pick (
        .vec_i   (req_all),
        .idx_o   (pick_id),
        .valid_o (pick_valid)
    );

    assign pick_base = ADDR_W'(CLIP_BASE[pick_id]);
    assign act_len   = ADDR_W'(CLIP_LEN[active_id_q]);
    assign in_clip   = (state_q == ST_LOAD) || (state_q == ST_PLAY);

    // Final cycle of the active clip (a zero-length clip completes in LOAD).
    assign last = ((state_q == ST_LOAD) && (act_len == '0)) ||
                  ((state_q == ST_PLAY) && (cnt_q == act_len - 1'b1));

    // Equal or higher id restarts at LOAD; on the final cycle completion wins
    // and the request simply stays pending.
    assign restart = in_clip && pick_valid && (pick_id >= active_id_q) && !last;

    // Next-state, ROM walk, pending bookkeeping and the done pulse.
    // NOTE: every variable gets a default at the top of the block, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        pending_d   = req_all;
        rom_addr_d  = rom_addr_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        active_id_d = active_id_q;
        done_pulse  = '0;
        grant       = 1'b0;

        if (cancel) begin
            state_d   = ST_IDLE;
            pending_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    grant = pick_valid;
                end
                ST_LOAD: begin
                    if (restart) begin
                        grant = 1'b1;
                    end else if (last) begin
                        done_pulse[active_id_q] = 1'b1;
                        state_d                 = ST_IDLE;
                    end else begin
                        state_d = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (restart) begin
                        grant = 1'b1;
                    end else if (last) begin
                        done_pulse[active_id_q] = 1'b1;
                        state_d                 = (GAP_LEN > 0) ? ST_GAP : ST_IDLE;
                        gap_d                   = '0;
                    end else begin
                        rom_addr_d = rom_addr_q + 1'b1;
                        cnt_d      = cnt_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_q == GAP_W'(GAP_LEN - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (grant) begin
                state_d            = ST_LOAD;
                active_id_d        = pick_id;
                rom_addr_d         = pick_base;
                cnt_d              = '0;
                pending_d[pick_id] = 1'b0;
            end
        end
    end

    // Only a sample fetched during PLAY reaches the speaker; cancel mutes at once.
    assign audio_d = ((state_q == ST_PLAY) && !cancel) ? rom_data : 8'd0;

    // State and datapath registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_8000 or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            rom_addr_q  <= '0;
            cnt_q       <= '0;
            gap_q       <= '0;
            active_id_q <= '0;
            audio_q     <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            rom_addr_q  <= rom_addr_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            active_id_q <= active_id_d;
            audio_q     <= audio_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign audio_out = audio_q;
    assign busy      = (state_q != ST_IDLE);
    assign active_id = active_id_q;
    assign done      = done_pulse;

endmodule

// File: tb/tb_sfx_scheduler.sv
// Directed bench for sfx_scheduler: single clip timing, preemption, low-priority
// queueing, cancel, retrigger, reset mid-clip and a request on the final sample.
module tb_sfx_scheduler;

    logic        clk_8000;
    logic        rst;
    logic [3:0]  req;
    logic        cancel;
    logic [7:0]  rom_data;
    logic [16:0] rom_addr;
    logic [7:0]  audio_out;
    logic        busy;
    logic [1:0]  active_id;
    logic [3:0]  done;

    int n_checks = 0;
    int n_fail   = 0;

    sfx_scheduler #(
        .NUM_REQ (4),
        .ADDR_W  (17),
        .GAP_LEN (16)
    ) dut (
        .clk_8000  (clk_8000),
        .rst       (rst),
        .req       (req),
        .cancel    (cancel),
        .rom_data  (rom_data),
        .rom_addr  (rom_addr),
        .audio_out (audio_out),
        .busy      (busy),
        .active_id (active_id),
        .done      (done)
    );

    initial clk_8000 = 1'b0;
    always #5 clk_8000 = ~clk_8000;

    function automatic logic [7:0] rom_f(input logic [16:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    // ROM model: data for an address appears one cycle later.
    always @(posedge clk_8000 or posedge rst) begin
        if (rst) rom_data <= 8'd0;
        else     rom_data <= rom_f(rom_addr);
    end

    task automatic step();
        @(posedge clk_8000);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Drive a one-cycle request; returns in the cycle after it was sampled.
    task automatic pulse_req(input logic [3:0] m);
        req = m;
        step();
        req = 4'd0;
    endtask

    // Step until busy drops, recording done activity relative to the call cycle.
    task automatic wait_idle(input int max_cyc, output int cyc, output int first_done,
                             output int done_cnt, output logic [3:0] done_or);
        cyc = 0; first_done = -1; done_cnt = 0; done_or = 4'd0;
        while (busy && cyc < max_cyc) begin
            if (done != 4'd0) begin
                done_cnt++;
                done_or |= done;
                if (first_done < 0) first_done = cyc;
            end
            step();
            cyc++;
        end
    endtask

    task automatic test_reset();
        step_n(2);
        n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_checks++; if (rom_addr !== 17'd0)  begin n_fail++; $display("FAIL reset_addr: got %0d want 0", rom_addr); end
        n_checks++; if (audio_out !== 8'd0)  begin n_fail++; $display("FAIL reset_audio: got %0d want 0", audio_out); end
        n_checks++; if (active_id !== 2'd0)  begin n_fail++; $display("FAIL reset_id: got %0d want 0", active_id); end
        n_checks++; if (done !== 4'd0)       begin n_fail++; $display("FAIL reset_done: got %b want 0000", done); end
        rst = 1'b0;
        step_n(2);
        n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL idle_busy: got %0b want 0", busy); end
    endtask

    task automatic test_single_clip();
        int n = 1;
        int addr_bad = 0, done_bad = 0, gap_bad = 0;
        logic [3:0] exp_done;
        pulse_req(4'b0001);
        n_checks++; if (busy !== 1'b1)      begin n_fail++; $display("FAIL single_load_busy: got %0b want 1", busy); end
        n_checks++; if (active_id !== 2'd0) begin n_fail++; $display("FAIL single_load_id: got %0d want 0", active_id); end
        n_checks++; if (rom_addr !== 17'd0) begin n_fail++; $display("FAIL single_load_addr: got %0d want 0", rom_addr); end
        while (busy && n < 7000) begin
            if (n >= 2 && n <= 6460 && rom_addr !== 17'(n - 2)) addr_bad++;
            exp_done = (n == 6460) ? 4'b0001 : 4'b0000;
            if (done !== exp_done) done_bad++;
            if (n >= 6462 && audio_out !== 8'd0) gap_bad++;
            if (n == 102) begin
                n_checks++;
                if (audio_out !== rom_f(17'd98)) begin
                    n_fail++; $display("FAIL single_audio: got %0h want %0h", audio_out, rom_f(17'd98));
                end
            end
            step();
            n++;
        end
        n_checks++; if (n != 6477)    begin n_fail++; $display("FAIL single_busy_len: got %0d want 6477", n); end
        n_checks++; if (addr_bad != 0) begin n_fail++; $display("FAIL single_addr_seq: got %0d bad want 0", addr_bad); end
        n_checks++; if (done_bad != 0) begin n_fail++; $display("FAIL single_done: got %0d bad want 0", done_bad); end
        n_checks++; if (gap_bad != 0)  begin n_fail++; $display("FAIL single_gap_audio: got %0d bad want 0", gap_bad); end
    endtask

    task automatic test_preempt();
        int cyc, first, cnt;
        logic [3:0] dor;
        pulse_req(4'b0001);
        step_n(101);
        n_checks++; if (rom_addr !== 17'd100) begin n_fail++; $display("FAIL pre_addr100: got %0d want 100", rom_addr); end
        req = 4'b0010;
        step();
        req = 4'd0;
        n_checks++; if (active_id !== 2'd1)    begin n_fail++; $display("FAIL pre_id: got %0d want 1", active_id); end
        n_checks++; if (rom_addr !== 17'd6459) begin n_fail++; $display("FAIL pre_addr: got %0d want 6459", rom_addr); end
        wait_idle(5000, cyc, first, cnt, dor);
        n_checks++; if (dor !== 4'b0010) begin n_fail++; $display("FAIL pre_done_ids: got %b want 0010", dor); end
        n_checks++; if (cnt != 1)        begin n_fail++; $display("FAIL pre_done_cnt: got %0d want 1", cnt); end
        n_checks++; if (first != 4000)   begin n_fail++; $display("FAIL pre_done_at: got %0d want 4000", first); end
        n_checks++; if (cyc != 4017)     begin n_fail++; $display("FAIL pre_idle_at: got %0d want 4017", cyc); end
    endtask

    task automatic test_low_pending();
        int cyc, first, cnt;
        logic [3:0] dor;
        pulse_req(4'b1000);
        n_checks++; if (rom_addr !== 17'd13459) begin n_fail++; $display("FAIL low_load_addr: got %0d want 13459", rom_addr); end
        step_n(10);
        req = 4'b0001;
        step();
        req = 4'd0;
        n_checks++; if (active_id !== 2'd3)     begin n_fail++; $display("FAIL low_keep_id: got %0d want 3", active_id); end
        n_checks++; if (rom_addr !== 17'd13469) begin n_fail++; $display("FAIL low_keep_addr: got %0d want 13469", rom_addr); end
        wait_idle(3000, cyc, first, cnt, dor);
        n_checks++; if (dor !== 4'b1000) begin n_fail++; $display("FAIL low_done_ids: got %b want 1000", dor); end
        n_checks++; if (cnt != 1)        begin n_fail++; $display("FAIL low_done_cnt: got %0d want 1", cnt); end
        n_checks++; if (first != 1989)   begin n_fail++; $display("FAIL low_done_at: got %0d want 1989", first); end
        n_checks++; if (cyc != 2006)     begin n_fail++; $display("FAIL low_idle_at: got %0d want 2006", cyc); end
        step();
        n_checks++; if (busy !== 1'b1)      begin n_fail++; $display("FAIL low_next_busy: got %0b want 1", busy); end
        n_checks++; if (active_id !== 2'd0) begin n_fail++; $display("FAIL low_next_id: got %0d want 0", active_id); end
        n_checks++; if (rom_addr !== 17'd0) begin n_fail++; $display("FAIL low_next_addr: got %0d want 0", rom_addr); end
    endtask

    // Runs on the clip 0 left playing by test_low_pending.
    task automatic test_cancel();
        int idle_bad = 0;
        step_n(20);
        req    = 4'b0100;
        cancel = 1'b1;
        #1;
        n_checks++; if (done !== 4'd0) begin n_fail++; $display("FAIL cancel_done: got %b want 0000", done); end
        step();
        req    = 4'd0;
        cancel = 1'b0;
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL cancel_busy: got %0b want 0", busy); end
        n_checks++; if (audio_out !== 8'd0) begin n_fail++; $display("FAIL cancel_audio: got %0d want 0", audio_out); end
        for (int i = 0; i < 4; i++) begin
            step();
            if (busy !== 1'b0 || audio_out !== 8'd0) idle_bad++;
        end
        n_checks++; if (idle_bad != 0) begin n_fail++; $display("FAIL cancel_dropped: got %0d bad want 0", idle_bad); end
    endtask

    task automatic test_retrigger();
        int cyc, first, cnt;
        logic [3:0] dor;
        pulse_req(4'b1000);
        step_n(501);
        n_checks++; if (rom_addr !== 17'd13959) begin n_fail++; $display("FAIL retrig_addr500: got %0d want 13959", rom_addr); end
        req = 4'b1000;
        step();
        req = 4'd0;
        n_checks++; if (rom_addr !== 17'd13459) begin n_fail++; $display("FAIL retrig_addr: got %0d want 13459", rom_addr); end
        n_checks++; if (active_id !== 2'd3)     begin n_fail++; $display("FAIL retrig_id: got %0d want 3", active_id); end
        wait_idle(3000, cyc, first, cnt, dor);
        n_checks++; if (dor !== 4'b1000) begin n_fail++; $display("FAIL retrig_done_ids: got %b want 1000", dor); end
        n_checks++; if (cnt != 1)        begin n_fail++; $display("FAIL retrig_done_cnt: got %0d want 1", cnt); end
        n_checks++; if (first != 2000)   begin n_fail++; $display("FAIL retrig_done_at: got %0d want 2000", first); end
        n_checks++; if (cyc != 2017)     begin n_fail++; $display("FAIL retrig_idle_at: got %0d want 2017", cyc); end
    endtask

    task automatic test_reset_mid_clip();
        pulse_req(4'b0100);
        step_n(51);
        n_checks++; if (rom_addr !== 17'd10509) begin n_fail++; $display("FAIL rstmid_addr50: got %0d want 10509", rom_addr); end
        rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL rstmid_busy: got %0b want 0", busy); end
        n_checks++; if (rom_addr !== 17'd0) begin n_fail++; $display("FAIL rstmid_addr: got %0d want 0", rom_addr); end
        n_checks++; if (audio_out !== 8'd0) begin n_fail++; $display("FAIL rstmid_audio: got %0d want 0", audio_out); end
        n_checks++; if (active_id !== 2'd0) begin n_fail++; $display("FAIL rstmid_id: got %0d want 0", active_id); end
        n_checks++; if (done !== 4'd0)      begin n_fail++; $display("FAIL rstmid_done: got %b want 0000", done); end
        step();
        rst = 1'b0;
        step();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_stay_idle: got %0b want 0", busy); end
    endtask

    // Fresh clip 2 after reset, with req[3] landing on its final sample.
    task automatic test_back_to_back();
        int n = 0, dcnt = 0, dbad = 0;
        logic [3:0] dor = 4'd0;
        pulse_req(4'b0100);
        n_checks++; if (rom_addr !== 17'd10459) begin n_fail++; $display("FAIL b2b_load_addr: got %0d want 10459", rom_addr); end
        while (busy && n < 4000) begin
            if (done != 4'd0) begin
                dcnt++;
                dor |= done;
                if (n != 3000) dbad++;
            end
            if (n == 3000) req = 4'b1000;
            step();
            req = 4'd0;
            n++;
        end
        n_checks++; if (n != 3017)       begin n_fail++; $display("FAIL b2b_idle_at: got %0d want 3017", n); end
        n_checks++; if (dcnt != 1)       begin n_fail++; $display("FAIL b2b_done_cnt: got %0d want 1", dcnt); end
        n_checks++; if (dor !== 4'b0100) begin n_fail++; $display("FAIL b2b_done_ids: got %b want 0100", dor); end
        n_checks++; if (dbad != 0)       begin n_fail++; $display("FAIL b2b_done_time: got %0d bad want 0", dbad); end
        step();
        n_checks++; if (active_id !== 2'd3)     begin n_fail++; $display("FAIL b2b_next_id: got %0d want 3", active_id); end
        n_checks++; if (rom_addr !== 17'd13459) begin n_fail++; $display("FAIL b2b_next_addr: got %0d want 13459", rom_addr); end
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_cancel_busy: got %0b want 0", busy); end
    endtask

    initial begin
        rst    = 1'b1;
        req    = 4'd0;
        cancel = 1'b0;
        test_reset();
        test_single_clip();
        test_preempt();
        test_low_pending();
        test_cancel();
        test_retrigger();
        test_reset_mid_clip();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
